che_hist_cnt: RTL

CHE_HIST_CNT -- requirements
Module: che_hist_cnt

---
 rtl/che_hist_cnt.sv | 101 ++++++++++
 1 files changed

// File: rtl/che_hist_cnt.sv
// Per-frame pixel histogram: counts beats per bin between sof and eof, publishes the snapshot on eof.
// Latency: eof beat at edge N -> hist_o/ovf_o/vld_o at edge N; no backpressure, every valid beat is taken.
module che_hist_cnt #(
    parameter  int DAT_WD  = 4,
    parameter  int CNT_WD  = 8,
    localparam int BIN_NUM = 2**DAT_WD
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        vld_i,
    input  logic [DAT_WD-1:0]           dat_i,
    input  logic                        sof_i,
    input  logic                        eof_i,
    output logic                        vld_o,
    output logic [CNT_WD*BIN_NUM-1:0]   hist_o,
    output logic                        ovf_o
);

    localparam logic [CNT_WD-1:0] CNT_MAX = '1;
    localparam logic [CNT_WD-1:0] CNT_ONE = CNT_WD'(1);

    typedef enum logic {IDLE, ACC} state_e;

    state_e                      state_q, state_d;
    logic [CNT_WD-1:0]           bin_q [BIN_NUM];
    logic [CNT_WD-1:0]           bin_d [BIN_NUM];
    logic                        ovf_q, ovf_d;
    logic [CNT_WD*BIN_NUM-1:0]   hist_q, hist_d;
    logic                        hovf_q, hovf_d;
    logic                        vld_q, vld_d;

    logic sof_hit, inc_hit, eof_hit;

    assign sof_hit = vld_i & sof_i;
    assign inc_hit = vld_i & ~sof_i & (state_q == ACC);
    assign eof_hit = vld_i & eof_i & (sof_i | (state_q == ACC));

    always_comb begin
        state_d = state_q;
        ovf_d   = ovf_q;
        hist_d  = hist_q;
        hovf_d  = hovf_q;
        vld_d   = 1'b0;
        for (int k = 0; k < BIN_NUM; k++) begin
            bin_d[k] = bin_q[k];
        end

        if (sof_hit) begin
            for (int k = 0; k < BIN_NUM; k++) begin
                bin_d[k] = '0;
            end
            bin_d[dat_i] = CNT_ONE;
            ovf_d        = 1'b0;
            state_d      = ACC;
        end else if (inc_hit) begin
            // Saturate rather than wrap; the sticky flag records the clipping.
            if (bin_q[dat_i] == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                bin_d[dat_i] = bin_q[dat_i] + CNT_ONE;
            end
        end

        // Snapshot includes the eof beat itself, hence bin_d/ovf_d.
        if (eof_hit) begin
            for (int k = 0; k < BIN_NUM; k++) begin
                hist_d[CNT_WD*k +: CNT_WD] = bin_d[k];
            end
            hovf_d  = ovf_d;
            vld_d   = 1'b1;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ovf_q   <= 1'b0;
            hist_q  <= '0;
            hovf_q  <= 1'b0;
            vld_q   <= 1'b0;
            for (int k = 0; k < BIN_NUM; k++) begin
                bin_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            ovf_q   <= ovf_d;
            hist_q  <= hist_d;
            hovf_q  <= hovf_d;
            vld_q   <= vld_d;
            for (int k = 0; k < BIN_NUM; k++) begin
                bin_q[k] <= bin_d[k];
            end
        end
    end

    assign vld_o  = vld_q;
    assign hist_o = hist_q;
    assign ovf_o  = hovf_q;

endmodule
